tri_diag_det_stream: RTL and testbench

TRI_DIAG_DET_STREAM -- requirements
Module: tri_diag_det_stream

---
 rtl/tri_diag_det_stream.sv | 178 +++++++++++++++++
 tb/tb_tri_diag_det_stream.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_diag_det_stream.sv
// -----------------------------------------------------------------------------
// tri_diag_det_stream
//
// Computes the determinant of an n x n tridiagonal matrix with the
// three-term recurrence
//    D_k = b[k-1]*D_{k-1} - a[k-2]*c[k-2]*D_{k-2},   D_0 = 1, D_{-1} = 0
// one k per clock. In mode 0 only D_n is emitted. In mode 1 every leading
// principal minor D_1..D_n is emitted as a separate word.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   job handshake (ready only while idle)
//   in_mode             0 = final determinant only, 1 = stream every minor
//   in_n                matrix order for this job (legal 1..N_MAX)
//   a_flat, c_flat      sub/super-diagonal, element 0 in the LSBs
//   b_flat              main diagonal, element 0 in the LSBs
//   out_valid/out_ready result handshake
//   out_data, out_idx   signed minor D_k and its index k
//   out_last            final word of the job
//   out_ovf             some D_j of this job did not fit OUT_WIDTH (sticky)
//   out_err             illegal n; out_data/out_idx are 0
//   busy                a job is in progress
// -----------------------------------------------------------------------------
module tri_diag_det_stream #(
   parameter  int N_MAX     = 16,
   parameter  int WIDTH     = 16,
   parameter  int OUT_WIDTH = 32,
   localparam int NW        = $clog2(N_MAX + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_mode,
   input  logic [NW-1:0]                 in_n,
   input  logic [WIDTH*(N_MAX-1)-1:0]    a_flat,
   input  logic [WIDTH*(N_MAX-1)-1:0]    c_flat,
   input  logic [WIDTH*N_MAX-1:0]        b_flat,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [OUT_WIDTH-1:0]   out_data,
   output logic [NW-1:0]                 out_idx,
   output logic                          out_last,
   output logic                          out_ovf,
   output logic                          out_err,
   output logic                          busy
);

   // Internal width holds b*D and a*c*D exactly, plus one bit for the subtraction.
   localparam int IW = 2*WIDTH + OUT_WIDTH + 1;
   localparam int AW = $clog2(N_MAX);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_EMIT = 2'd2;

   logic [1:0]                        state;
   logic [NW-1:0]                     k;
   logic [NW-1:0]                     n_q;
   logic                              mode_q;
   logic signed [OUT_WIDTH-1:0]       d1;      // D_{k-1}, stored wrapped
   logic signed [OUT_WIDTH-1:0]       d2;      // D_{k-2}, stored wrapped
   logic [N_MAX-1:0][WIDTH-1:0]       a_q;     // top entry is padding, never read
   logic [N_MAX-1:0][WIDTH-1:0]       b_q;
   logic [N_MAX-1:0][WIDTH-1:0]       c_q;

   logic [AW-1:0]                     b_idx;
   logic [AW-1:0]                     ac_idx;
   logic signed [WIDTH-1:0]           a_s, b_s, c_s;
   logic signed [IW-1:0]              a_x, b_x, c_x, d1_x, d2_x;
   logic signed [IW-1:0]              full;
   logic signed [OUT_WIDTH-1:0]       d_new;
   logic                              fits;
   logic                              k_is_last;
   logic                              n_legal;

   assign in_ready  = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign out_valid = (state == S_EMIT);

   // For k = 1 the a*c term is multiplied by D_{-1} = 0, so any index will do.
   assign b_idx  = AW'(k - 1'b1);
   assign ac_idx = (k >= NW'(2)) ? AW'(k - NW'(2)) : '0;

   assign a_s = a_q[ac_idx];
   assign b_s = b_q[b_idx];
   assign c_s = c_q[ac_idx];

   assign a_x  = {{(IW-WIDTH){a_s[WIDTH-1]}}, a_s};
   assign b_x  = {{(IW-WIDTH){b_s[WIDTH-1]}}, b_s};
   assign c_x  = {{(IW-WIDTH){c_s[WIDTH-1]}}, c_s};
   assign d1_x = {{(IW-OUT_WIDTH){d1[OUT_WIDTH-1]}}, d1};
   assign d2_x = {{(IW-OUT_WIDTH){d2[OUT_WIDTH-1]}}, d2};

   assign full  = b_x * d1_x - a_x * c_x * d2_x;
   assign d_new = full[OUT_WIDTH-1:0];
   // The exact value fits iff it equals the sign extension of its truncation.
   assign fits  = (full == {{(IW-OUT_WIDTH){d_new[OUT_WIDTH-1]}}, d_new});

   assign k_is_last = (k == n_q);
   assign n_legal   = (in_n != '0) && (in_n <= NW'(N_MAX));

   // NOTE: the captured diagonals are pure data qualified by state, so they
   // carry no reset; this keeps rst off the wide operand registers.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && in_valid) begin
         a_q <= {WIDTH'(0), a_flat};
         b_q <= b_flat;
         c_q <= c_flat;
      end
   end

   // NOTE: every register here uses non-blocking assignment so that d2 takes
   // the old d1 while d1 takes the new minor within the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         k        <= '0;
         n_q      <= '0;
         mode_q   <= 1'b0;
         d1       <= '0;
         d2       <= '0;
         out_data <= '0;
         out_idx  <= '0;
         out_last <= 1'b0;
         out_ovf  <= 1'b0;
         out_err  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  n_q     <= in_n;
                  mode_q  <= in_mode;
                  out_ovf <= 1'b0;
                  if (n_legal) begin
                     state   <= S_CALC;
                     k       <= NW'(1);
                     d1      <= OUT_WIDTH'(1);
                     d2      <= '0;
                     out_err <= 1'b0;
                  end else begin
                     state    <= S_EMIT;
                     out_data <= '0;
                     out_idx  <= '0;
                     out_last <= 1'b1;
                     out_err  <= 1'b1;
                  end
               end
            end
            S_CALC: begin
               d2 <= d1;
               d1 <= d_new;
               if (!fits) out_ovf <= 1'b1;
               if (mode_q || k_is_last) begin
                  state    <= S_EMIT;
                  out_data <= d_new;
                  out_idx  <= k;
                  out_last <= k_is_last;
               end else begin
                  k <= k + 1'b1;
               end
            end
            S_EMIT: begin
               if (out_ready) begin
                  if (out_last) begin
                     state <= S_IDLE;
                  end else begin
                     state <= S_CALC;
                     k     <= k + 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tri_diag_det_stream.sv
// -----------------------------------------------------------------------------
// tb_tri_diag_det_stream
//
// Self-checking bench for tri_diag_det_stream. A reference model evaluates the
// determinant recurrence with 64-bit integer arithmetic and queues the words
// each job must produce; scenario tasks drive jobs and compare every output
// word, its latency, and its stability under back-pressure.
// -----------------------------------------------------------------------------
module tb_tri_diag_det_stream;

   localparam int N_MAX     = 16;
   localparam int WIDTH     = 16;
   localparam int OUT_WIDTH = 32;
   localparam int NW        = $clog2(N_MAX + 1);

   logic                         clk = 1'b0;
   logic                         rst;
   logic                         in_valid;
   logic                         in_ready;
   logic                         in_mode;
   logic [NW-1:0]                in_n;
   logic [WIDTH*(N_MAX-1)-1:0]   a_flat;
   logic [WIDTH*(N_MAX-1)-1:0]   c_flat;
   logic [WIDTH*N_MAX-1:0]       b_flat;
   logic                         out_valid;
   logic                         out_ready;
   logic signed [OUT_WIDTH-1:0]  out_data;
   logic [NW-1:0]                out_idx;
   logic                         out_last;
   logic                         out_ovf;
   logic                         out_err;
   logic                         busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tri_diag_det_stream #(
      .N_MAX     (N_MAX),
      .WIDTH     (WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_n      (in_n),
      .a_flat    (a_flat),
      .c_flat    (c_flat),
      .b_flat    (b_flat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .out_ovf   (out_ovf),
      .out_err   (out_err),
      .busy      (busy)
   );

   typedef struct {
      longint data;
      int     idx;
      bit     last;
      bit     ovf;
      bit     err;
   } word_t;

   word_t exp_q[$];

   // Current job description (signed element values).
   int ja[N_MAX];
   int jb[N_MAX];
   int jc[N_MAX];
   int jn;
   bit jmode;
   int cur_lat;

   // Reference model: determinant recurrence in 64-bit arithmetic, each minor
   // wrapped to 32 bits before it feeds the next step.
   function automatic void model();
      longint dm1 = 1;
      longint dm2 = 0;
      longint full;
      int     tr;
      bit     ovf = 1'b0;
      word_t  w;
      if (jn < 1 || jn > N_MAX) begin
         w = '{0, 0, 1'b1, 1'b0, 1'b1};
         exp_q.push_back(w);
         return;
      end
      for (int k = 1; k <= jn; k++) begin
         full = longint'(jb[k-1]) * dm1;
         if (k >= 2) full = full - longint'(ja[k-2]) * longint'(jc[k-2]) * dm2;
         tr = int'(full);
         if (longint'(tr) != full) ovf = 1'b1;
         dm2 = dm1;
         dm1 = longint'(tr);
         if (jmode || k == jn) begin
            w = '{longint'(tr), k, (k == jn), ovf, 1'b0};
            exp_q.push_back(w);
         end
      end
   endfunction

   task automatic set_tri(input int n, input bit mode, input int bv, input int av, input int cv);
      jn = n;
      jmode = mode;
      for (int i = 0; i < N_MAX; i++) begin
         jb[i] = bv;
         ja[i] = av;
         jc[i] = cv;
      end
   endtask

   task automatic set_random(input int n, input bit mode);
      jn = n;
      jmode = mode;
      for (int i = 0; i < N_MAX; i++) begin
         jb[i] = int'($urandom_range(65535)) - 32768;
         ja[i] = int'($urandom_range(65535)) - 32768;
         jc[i] = int'($urandom_range(65535)) - 32768;
      end
   endtask

   task automatic drive_ports();
      in_n    = NW'(jn);
      in_mode = jmode;
      for (int i = 0; i < N_MAX - 1; i++) begin
         a_flat[i*WIDTH +: WIDTH] = WIDTH'(ja[i]);
         c_flat[i*WIDTH +: WIDTH] = WIDTH'(jc[i]);
      end
      for (int i = 0; i < N_MAX; i++) b_flat[i*WIDTH +: WIDTH] = WIDTH'(jb[i]);
   endtask

   task automatic scramble_ports();
      in_n    = NW'($urandom);
      in_mode = 1'($urandom);
      for (int i = 0; i < N_MAX - 1; i++) begin
         a_flat[i*WIDTH +: WIDTH] = WIDTH'($urandom);
         c_flat[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
      for (int i = 0; i < N_MAX; i++) b_flat[i*WIDTH +: WIDTH] = WIDTH'($urandom);
   endtask

   // Queue the expected words, present the job and wait for acceptance.
   // Returns in the cycle after the accepting edge, with inputs scrambled.
   task automatic start_job(input bit expect_now);
      int w;
      model();
      drive_ports();
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      checks++;
      if (in_ready !== 1'b1 || (expect_now && w != 0)) begin
         errors++;
         $display("FAIL accept: in_ready=%b after %0d wait cycles, required in_ready=1 after %0s",
                  in_ready, w, expect_now ? "0" : "<100");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      scramble_ports();
      cur_lat = (jn < 1 || jn > N_MAX) ? 1 : (jmode ? 2 : jn + 1);
   endtask

   // Drain every queued word: latency, content, hold-under-stall and the
   // return to idle after the last word. With chain set, the next job (held
   // in the job globals) is offered on the same cycle as the final handshake.
   task automatic collect(input int ready_pct, input int stall_idx, input int stall_len, input bit chain);
      word_t e;
      int    c;
      int    lat;
      int    held;
      bit    rdy;
      lat = cur_lat;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         c = 1;
         while (!out_valid && c < 300) begin
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
               errors++;
               $display("FAIL calc_flags: busy=%b in_ready=%b, required busy=1 in_ready=0", busy, in_ready);
            end
            @(posedge clk); #1;
            c++;
         end
         checks++;
         if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout: no out_valid for word k=%0d within %0d cycles", e.idx, c);
            exp_q.delete();
            return;
         end
         checks++;
         if (c != lat) begin
            errors++;
            $display("FAIL latency k=%0d: word after %0d cycles, required %0d", e.idx, c, lat);
         end
         checks++;
         if (out_data !== OUT_WIDTH'(e.data) || out_idx !== NW'(e.idx) || out_last !== e.last ||
             out_ovf !== e.ovf || out_err !== e.err || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL word: data=%0d idx=%0d last=%b ovf=%b err=%b busy=%b rdy=%b, required data=%0d idx=%0d last=%b ovf=%b err=%b busy=1 rdy=0",
                     out_data, out_idx, out_last, out_ovf, out_err, busy, in_ready,
                     e.data, e.idx, e.last, e.ovf, e.err);
         end
         held = 0;
         while (1) begin
            if (e.idx == stall_idx) rdy = (held >= stall_len);
            else                    rdy = ($urandom_range(99) < ready_pct);
            out_ready = rdy;
            if (rdy && e.last && chain) begin
               drive_ports();
               in_valid = 1'b1;
            end
            @(posedge clk); #1;
            if (rdy) break;
            held++;
            checks++;
            if (out_valid !== 1'b1 || out_data !== OUT_WIDTH'(e.data) || out_idx !== NW'(e.idx) ||
                out_last !== e.last || out_ovf !== e.ovf || out_err !== e.err) begin
               errors++;
               $display("FAIL stall_hold k=%0d: valid=%b data=%0d idx=%0d last=%b ovf=%b err=%b, required held word data=%0d",
                        e.idx, out_valid, out_data, out_idx, out_last, out_ovf, out_err, e.data);
            end
         end
         lat = 2;
         if (e.last) begin
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
               errors++;
               $display("FAIL after_last: valid=%b busy=%b in_ready=%b, required 0/0/1", out_valid, busy, in_ready);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      scramble_ports();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ctrl: valid=%b busy=%b in_ready=%b, required 0/0/1", out_valid, busy, in_ready);
      end
      checks++;
      if (out_data !== '0 || out_idx !== '0 || out_last !== 1'b0 || out_ovf !== 1'b0 || out_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_data: data=%0d idx=%0d last=%b ovf=%b err=%b, required all 0",
                  out_data, out_idx, out_last, out_ovf, out_err);
      end
   endtask

   task automatic test_mode0_basic();
      set_tri(3, 1'b0, 2, 1, 1);
      start_job(1'b1);
      collect(100, -1, 0, 1'b0);
   endtask

   task automatic test_mode1_stall();
      set_tri(3, 1'b1, 2, 1, 1);
      start_job(1'b1);
      collect(100, 2, 5, 1'b0);
   endtask

   task automatic test_small_and_illegal();
      set_tri(1, 1'b0, -7, 3, 3);
      start_job(1'b1);
      collect(100, -1, 0, 1'b0);
      set_random(0, 1'b1);
      start_job(1'b1);
      collect(100, -1, 0, 1'b0);
      set_random(17, 1'b0);
      start_job(1'b1);
      collect(50, 0, 3, 1'b0);
   endtask

   task automatic test_overflow();
      set_tri(3, 1'b1, 32767, 0, 0);
      start_job(1'b1);
      collect(100, -1, 0, 1'b0);
   endtask

   task automatic test_reset_mid_job();
      bit seen;
      set_random(16, 1'b0);
      out_ready = 1'b1;
      start_job(1'b1);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (out_valid === 1'b1) seen = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (seen || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_abandon: out_valid_seen=%b busy=%b in_ready=%b, required 0/0/1", seen, busy, in_ready);
      end
      set_tri(2, 1'b0, 0, 5, 5);
      jb[0] = 3;
      jb[1] = 4;
      start_job(1'b1);
      collect(100, -1, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      set_tri(3, 1'b0, 32767, 0, 0);
      start_job(1'b1);
      set_random(4, 1'b1);
      for (int i = 0; i < N_MAX; i++) begin
         jb[i] = int'($urandom_range(20)) - 10;
         ja[i] = int'($urandom_range(20)) - 10;
         jc[i] = int'($urandom_range(20)) - 10;
      end
      collect(100, -1, 0, 1'b1);
      start_job(1'b1);
      collect(100, -1, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int j = 0; j < 25; j++) begin
         set_random(int'($urandom_range(20)), 1'($urandom));
         start_job(1'b1);
         collect(60, -1, 0, 1'b0);
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_n = '0;
      in_mode = 1'b0;
      a_flat = '0;
      b_flat = '0;
      c_flat = '0;
      @(posedge clk); #1;
      test_reset();
      test_mode0_basic();
      test_mode1_stall();
      test_small_and_illegal();
      test_overflow();
      test_reset_mid_job();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
